// File: rtl/time_event_scheduler.sv
// Timekeeping controller: queues 1 Hz and button requests, services one per cycle
// in fixed priority into the time/alarm registers, and runs the alarm ring/lockout FSM.
module time_event_scheduler #(
  parameter int ALARM_SECS = 60,
  parameter int AL_STEP    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       sec_adj,
  input  logic       min_adj,
  input  logic       hrs_adj,
  input  logic       al_adj,
  input  logic       al_toggle,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [3:0] hours,
  output logic [5:0] al_minutes,
  output logic [3:0] al_hours,
  output logic       al_on,
  output logic       alarm,
  output logic       busy,
  output logic       dropped,
  output logic [1:0] dbg_state_o
);

  // Request bit positions; lower index = higher service priority.
  localparam int SRC_TICK   = 0;
  localparam int SRC_SEC    = 1;
  localparam int SRC_MIN    = 2;
  localparam int SRC_HRS    = 3;
  localparam int SRC_AL     = 4;
  localparam int SRC_TOGGLE = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RING    = 2'd1,
    ST_LOCKOUT = 2'd2
  } alarm_state_e;

  logic [5:0]   pending_q, pending_d;
  logic         dropped_q, dropped_d;
  logic [5:0]   sec_q, sec_d;
  logic [5:0]   min_q, min_d;
  logic [3:0]   hrs_q, hrs_d;
  logic [5:0]   alm_q, alm_d;
  logic [3:0]   alh_q, alh_d;
  logic         al_on_q, al_on_d;
  logic [7:0]   ring_q, ring_d;
  alarm_state_e state_q, state_d;

  logic [5:0] req;
  logic [5:0] grant;
  logic [6:0] al_sum;
  logic [7:0] ring_inc;
  logic       match;

  assign req = {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, tick_1hz};

  always_comb begin
    grant = '0;
    if (pending_q[SRC_TICK])        grant[SRC_TICK]   = 1'b1;
    else if (pending_q[SRC_SEC])    grant[SRC_SEC]    = 1'b1;
    else if (pending_q[SRC_MIN])    grant[SRC_MIN]    = 1'b1;
    else if (pending_q[SRC_HRS])    grant[SRC_HRS]    = 1'b1;
    else if (pending_q[SRC_AL])     grant[SRC_AL]     = 1'b1;
    else if (pending_q[SRC_TOGGLE]) grant[SRC_TOGGLE] = 1'b1;
  end

  // A pulse on the bit being serviced this cycle simply re-arms it; only a pulse
  // landing on a bit that stays set is a lost request.
  always_comb begin
    pending_d = (pending_q & ~grant) | req;
    dropped_d = dropped_q | (|(req & pending_q & ~grant));
  end

  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hrs_d   = hrs_q;
    alm_d   = alm_q;
    alh_d   = alh_q;
    al_on_d = al_on_q;
    al_sum  = {1'b0, alm_q} + 7'(AL_STEP);

    if (grant[SRC_TICK] || grant[SRC_SEC]) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          hrs_d = (hrs_q == 4'd11) ? 4'd0 : hrs_q + 4'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    if (grant[SRC_MIN]) begin
      min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    end

    if (grant[SRC_HRS]) begin
      hrs_d = (hrs_q == 4'd11) ? 4'd0 : hrs_q + 4'd1;
    end

    if (grant[SRC_AL]) begin
      if (al_sum >= 7'd60) begin
        alm_d = 6'(al_sum - 7'd60);
        alh_d = (alh_q == 4'd11) ? 4'd0 : alh_q + 4'd1;
      end else begin
        alm_d = al_sum[5:0];
      end
    end

    if (grant[SRC_TOGGLE]) begin
      al_on_d = ~al_on_q;
    end
  end

  assign match    = (hrs_q == alh_q) && (min_q == alm_q);
  assign ring_inc = ring_q + 8'd1;

  // Disarm wins from every state; otherwise ring until timeout, then hold off
  // re-triggering until the time moves away from the alarm time.
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    if (!al_on_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match) begin
            state_d = ST_RING;
            ring_d  = 8'd0;
          end
        end
        ST_RING: begin
          if (grant[SRC_TICK]) begin
            ring_d = ring_inc;
            if (ring_inc == 8'(ALARM_SECS)) state_d = ST_LOCKOUT;
          end
        end
        ST_LOCKOUT: begin
          if (!match) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      dropped_q <= 1'b0;
      sec_q     <= '0;
      min_q     <= '0;
      hrs_q     <= '0;
      alm_q     <= '0;
      alh_q     <= '0;
      al_on_q   <= 1'b0;
      ring_q    <= '0;
      state_q   <= ST_IDLE;
    end else begin
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hrs_q     <= hrs_d;
      alm_q     <= alm_d;
      alh_q     <= alh_d;
      al_on_q   <= al_on_d;
      ring_q    <= ring_d;
      state_q   <= state_d;
    end
  end

  assign seconds     = sec_q;
  assign minutes     = min_q;
  assign hours       = hrs_q;
  assign al_minutes  = alm_q;
  assign al_hours    = alh_q;
  assign al_on       = al_on_q;
  assign alarm       = (state_q == ST_RING);
  assign busy        = |pending_q;
  assign dropped     = dropped_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_time_event_scheduler.sv
// Bench for time_event_scheduler: vector table for priority/coalescing plus
// hand-written sequences for reset, carry cascade, alarm wrap and alarm lifecycle.
module tb_time_event_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0, sec_adj = 1'b0, min_adj = 1'b0;
  logic       hrs_adj = 1'b0, al_adj = 1'b0, al_toggle = 1'b0;
  logic [5:0] seconds, minutes, al_minutes;
  logic [3:0] hours, al_hours;
  logic       al_on, alarm, busy, dropped;
  logic [1:0] dbg_state;

  localparam logic [5:0] M_TICK = 6'b000001;
  localparam logic [5:0] M_SEC  = 6'b000010;
  localparam logic [5:0] M_MIN  = 6'b000100;
  localparam logic [5:0] M_HRS  = 6'b001000;
  localparam logic [5:0] M_AL   = 6'b010000;
  localparam logic [5:0] M_TOG  = 6'b100000;

  localparam int S_IDLE = 0, S_RING = 1, S_LOCK = 2;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [3:0] hrs;
    logic [5:0] alm;
    logic [3:0] alh;
    logic       on;
    logic       alrm;
    logic       bsy;
    logic       drp;
    logic [1:0] st;
  } obs_t;

  typedef struct {
    logic [5:0] mask;
    int         extra;
    obs_t       exp;
    string      name;
  } vec_t;

  logic [31:0] exp_q[$];
  int n_compared = 0;
  int n_mismatched = 0;
  vec_t tbl[12];

  time_event_scheduler dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .sec_adj(sec_adj),
    .min_adj(min_adj), .hrs_adj(hrs_adj), .al_adj(al_adj), .al_toggle(al_toggle),
    .seconds(seconds), .minutes(minutes), .hours(hours), .al_minutes(al_minutes),
    .al_hours(al_hours), .al_on(al_on), .alarm(alarm), .busy(busy),
    .dropped(dropped), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic obs_t mk(int s, int m, int h, int am, int ah,
                              int on, int alrm, int bsy, int drp, int st);
    obs_t o;
    o.sec = 6'(s); o.min = 6'(m); o.hrs = 4'(h); o.alm = 6'(am); o.alh = 4'(ah);
    o.on = 1'(on); o.alrm = 1'(alrm); o.bsy = 1'(bsy); o.drp = 1'(drp); o.st = 2'(st);
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = {seconds, minutes, hours, al_minutes, al_hours, al_on, alarm, busy, dropped, dbg_state};
    return o;
  endfunction

  // Driver tasks: all start and end on a falling edge.
  task automatic set_req(input logic [5:0] m);
    {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, tick_1hz} = m;
  endtask

  task automatic pop_check(input string name);
    obs_t got, exp;
    exp = obs_t'(exp_q.pop_front());
    got = observe();
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got s=%0d m=%0d h=%0d am=%0d ah=%0d on=%b alarm=%b busy=%b drop=%b st=%0d, expected s=%0d m=%0d h=%0d am=%0d ah=%0d on=%b alarm=%b busy=%b drop=%b st=%0d",
               name, got.sec, got.min, got.hrs, got.alm, got.alh, got.on, got.alrm, got.bsy, got.drp, got.st,
               exp.sec, exp.min, exp.hrs, exp.alm, exp.alh, exp.on, exp.alrm, exp.bsy, exp.drp, exp.st);
    end
  endtask

  task automatic check_now(input string name, input obs_t exp);
    exp_q.push_back(32'(exp));
    pop_check(name);
  endtask

  // One clock with mask asserted, then extra idle clocks, then compare.
  task automatic apply(input logic [5:0] m, input int extra, input obs_t exp, input string name);
    exp_q.push_back(32'(exp));
    set_req(m);
    @(negedge clk);
    set_req(6'b0);
    repeat (extra) @(negedge clk);
    pop_check(name);
  endtask

  task automatic burst(input logic [5:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      set_req(m);
      @(negedge clk);
    end
    set_req(6'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req(6'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    burst(M_HRS, h);
    burst(M_MIN, m);
    burst(M_SEC, s);
    idle(2);
  endtask

  initial begin
    // Priority order with all six at once, then coalescing behaviour.
    tbl[0]  = '{6'h3F, 1, mk(1,0,0,0,0,0,0,1,0,S_IDLE),  "all6_tick"};
    tbl[1]  = '{6'h00, 0, mk(2,0,0,0,0,0,0,1,0,S_IDLE),  "all6_sec"};
    tbl[2]  = '{6'h00, 0, mk(2,1,0,0,0,0,0,1,0,S_IDLE),  "all6_min"};
    tbl[3]  = '{6'h00, 0, mk(2,1,1,0,0,0,0,1,0,S_IDLE),  "all6_hrs"};
    tbl[4]  = '{6'h00, 0, mk(2,1,1,10,0,0,0,1,0,S_IDLE), "all6_al"};
    tbl[5]  = '{6'h00, 0, mk(2,1,1,10,0,1,0,0,0,S_IDLE), "all6_toggle"};
    tbl[6]  = '{M_TICK | M_MIN, 0, mk(2,1,1,10,0,1,0,1,0,S_IDLE), "coal_queue"};
    tbl[7]  = '{6'h00, 0, mk(3,1,1,10,0,1,0,1,0,S_IDLE), "coal_tick_first"};
    tbl[8]  = '{M_MIN, 0, mk(3,2,1,10,0,1,0,1,0,S_IDLE), "coal_rearm_no_drop"};
    tbl[9]  = '{M_TICK | M_MIN, 0, mk(3,3,1,10,0,1,0,1,0,S_IDLE), "coal_rearm_again"};
    tbl[10] = '{M_MIN, 0, mk(4,3,1,10,0,1,0,1,1,S_IDLE), "coal_drop"};
    tbl[11] = '{6'h00, 0, mk(4,4,1,10,0,1,0,0,1,S_IDLE), "coal_drain_sticky"};

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_now("reset_state", mk(0,0,0,0,0,0,0,0,0,S_IDLE));

    foreach (tbl[i]) apply(tbl[i].mask, tbl[i].extra, tbl[i].exp, tbl[i].name);

    // Reset mid-operation with requests pending.
    do_reset();
    set_time(5, 59, 59);
    check_now("preset_5_59_59", mk(59,59,5,0,0,0,0,0,0,S_IDLE));
    set_req(M_TICK | M_MIN);
    @(negedge clk);
    set_req(6'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_now("reset_mid_op", mk(0,0,0,0,0,0,0,0,0,S_IDLE));
    idle(1);
    check_now("reset_pending_cleared", mk(0,0,0,0,0,0,0,0,0,S_IDLE));
    apply(M_TICK, 1, mk(1,0,0,0,0,0,0,0,0,S_IDLE), "tick_after_reset");

    // Full carry cascade in one step.
    do_reset();
    set_time(11, 59, 59);
    check_now("preset_11_59_59", mk(59,59,11,0,0,0,0,0,0,S_IDLE));
    apply(M_TICK, 0, mk(59,59,11,0,0,0,0,1,0,S_IDLE), "carry_pending");
    apply(6'h00, 0, mk(0,0,0,0,0,0,0,0,0,S_IDLE), "carry_cascade");

    // Alarm-time step and wrap; back-to-back pulses must not count as drops.
    do_reset();
    burst(M_AL, 71);
    idle(2);
    check_now("al_11_50", mk(0,0,0,50,11,0,0,0,0,S_IDLE));
    apply(M_AL, 1, mk(0,0,0,0,0,0,0,0,0,S_IDLE), "al_wrap");

    // Alarm lifecycle: arm at match, ring for ALARM_SECS ticks, lockout, idle.
    do_reset();
    apply(M_TOG, 1, mk(0,0,0,0,0,1,0,0,0,S_IDLE), "arm");
    apply(6'h00, 0, mk(0,0,0,0,0,1,1,0,0,S_RING), "ring_start");
    burst(M_TICK, 59);
    idle(1);
    check_now("ring_59_ticks", mk(59,0,0,0,0,1,1,0,0,S_RING));
    apply(M_TICK, 1, mk(0,1,0,0,0,1,0,0,0,S_LOCK), "ring_timeout");
    apply(6'h00, 0, mk(0,1,0,0,0,1,0,0,0,S_IDLE), "lockout_release");

    // Disarm during ring; time adjust while ringing keeps it ringing.
    do_reset();
    apply(M_TOG, 1, mk(0,0,0,0,0,1,0,0,0,S_IDLE), "arm2");
    apply(6'h00, 0, mk(0,0,0,0,0,1,1,0,0,S_RING), "ring2_start");
    apply(M_MIN, 1, mk(0,1,0,0,0,1,1,0,0,S_RING), "adjust_keeps_ring");
    apply(M_TOG, 0, mk(0,1,0,0,0,1,1,1,0,S_RING), "disarm_pending");
    apply(6'h00, 0, mk(0,1,0,0,0,0,1,0,0,S_RING), "disarm_serviced");
    apply(6'h00, 0, mk(0,1,0,0,0,0,0,0,0,S_IDLE), "disarm_silenced");

    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
